// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between the core (C) and the host loader (H)
module dmem_arbiter #(
   parameter int p_ADDR_LEN = 16,
   parameter int p_WORD_LEN = 16,
   parameter int p_MAX_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [p_ADDR_LEN-1:0] c_addr,
   input  logic [p_WORD_LEN-1:0] c_wdata,
   output logic                  c_gnt,
   output logic                  c_stall,
   output logic                  c_rvalid,
   output logic [p_WORD_LEN-1:0] c_rdata,
   input  logic                  h_req,
   input  logic                  h_we,
   input  logic [p_ADDR_LEN-1:0] h_addr,
   input  logic [p_WORD_LEN-1:0] h_wdata,
   input  logic                  h_lock,
   output logic                  h_gnt,
   output logic                  h_rvalid,
   output logic [p_WORD_LEN-1:0] h_rdata,
   output logic [p_ADDR_LEN-1:0] m_addr,
   output logic [p_WORD_LEN-1:0] m_wdata,
   output logic                  m_wen,
   input  logic [p_WORD_LEN-1:0] m_rdata
);

   localparam int HOLD_W = $clog2(p_MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(p_MAX_HOLD);

   logic                  last_win;
   logic [HOLD_W-1:0]     hold_cnt;
   logic                  c_rvalid_q, h_rvalid_q;
   logic [p_WORD_LEN-1:0] c_rdata_q, h_rdata_q;
   logic                  lock_pri;

   always_comb begin
      lock_pri = h_lock && (hold_cnt < HOLD_MAX);
      c_gnt    = 1'b0;
      h_gnt    = 1'b0;
      if (!rst) begin
         if (c_req && h_req) begin
            // last_win = 0 means the core won last, so the host gets its turn
            if (lock_pri || !last_win) h_gnt = 1'b1;
            else                       c_gnt = 1'b1;
         end else begin
            c_gnt = c_req;
            h_gnt = h_req;
         end
      end

      m_addr  = '0;
      m_wdata = '0;
      m_wen   = 1'b0;
      if (c_gnt) begin
         m_addr  = c_addr;
         m_wdata = c_wdata;
         m_wen   = c_we;
      end else if (h_gnt) begin
         m_addr  = h_addr;
         m_wdata = h_wdata;
         m_wen   = h_we;
      end
   end

   assign c_stall = c_req & ~c_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_win   <= 1'b1;
         hold_cnt   <= '0;
         c_rvalid_q <= 1'b0;
         h_rvalid_q <= 1'b0;
         c_rdata_q  <= '0;
         h_rdata_q  <= '0;
      end else begin
         c_rvalid_q <= c_gnt & ~c_we;
         h_rvalid_q <= h_gnt & ~h_we;
         if (c_gnt && !c_we) c_rdata_q <= m_rdata;
         if (h_gnt && !h_we) h_rdata_q <= m_rdata;

         if (c_gnt)      last_win <= 1'b0;
         else if (h_gnt) last_win <= 1'b1;

         if (h_gnt && c_req) begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
         end else if (c_gnt || !c_req) begin
            hold_cnt <= '0;
         end
      end
   end

   // Masking by rst drops a response still pending when reset arrives
   assign c_rvalid = c_rvalid_q & ~rst;
   assign h_rvalid = h_rvalid_q & ~rst;
   assign c_rdata  = rst ? '0 : c_rdata_q;
   assign h_rdata  = rst ? '0 : h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int MAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_req = 0, c_we = 0, h_req = 0, h_we = 0, h_lock = 0;
   logic [15:0] c_addr = 0, c_wdata = 0, h_addr = 0, h_wdata = 0;
   logic        c_gnt, c_stall, c_rvalid, h_gnt, h_rvalid, m_wen;
   logic [15:0] c_rdata, h_rdata, m_addr, m_wdata, m_rdata;

   logic [15:0] env_mem [0:255];
   logic [15:0] ref_mem [0:255];

   always #5 clk = ~clk;

   dmem_arbiter #(.p_ADDR_LEN(16), .p_WORD_LEN(16), .p_MAX_HOLD(MAX)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_rdata(m_rdata)
   );

   assign m_rdata = env_mem[m_addr[7:0]];
   always @(posedge clk) if (m_wen) env_mem[m_addr[7:0]] <= m_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state: last winner (0 core, 1 host), host streak, visible responses
   int          mdl_last = 1;
   int          mdl_hold = 0;
   logic        mdl_crv = 0, mdl_hrv = 0;
   logic [15:0] mdl_crd = 0, mdl_hrd = 0;
   int          starve = 0;

   logic        snap_cg, snap_hg, snap_crv, snap_hrv;
   logic [15:0] snap_crd, snap_hrd;

   typedef struct {
      logic rs, cr, cw; logic [15:0] ca, cd;
      logic hr, hw; logic [15:0] ha, hd; logic lk;
      int eg;
      logic chk, ecv; logic [15:0] ecd; logic ehv; logic [15:0] ehd;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // 0 none, 1 core, 2 host
   function automatic int pick(input logic cr, input logic hr, input logic lk);
      if (!cr && !hr) return 0;
      if (cr && !hr)  return 1;
      if (hr && !cr)  return 2;
      if (lk && mdl_hold < MAX) return 2;
      return (mdl_last == 1) ? 1 : 2;
   endfunction

   function automatic vec_t mk(input logic rs, cr, cw, input logic [15:0] ca, cd,
                               input logic hr, hw, input logic [15:0] ha, hd,
                               input logic lk, input int eg);
      vec_t v;
      v.rs = rs; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd; v.lk = lk; v.eg = eg;
      v.chk = 0; v.ecv = 0; v.ecd = 0; v.ehv = 0; v.ehd = 0;
      return v;
   endfunction

   task automatic post(input logic cv, input logic [15:0] cd, input logic hv, input logic [15:0] hd);
      tbl[tbl.size()-1].chk = 1;
      tbl[tbl.size()-1].ecv = cv;
      tbl[tbl.size()-1].ecd = cd;
      tbl[tbl.size()-1].ehv = hv;
      tbl[tbl.size()-1].ehd = hd;
   endtask

   task automatic drive(input vec_t v);
      rst = v.rs; c_req = v.cr; c_we = v.cw; c_addr = v.ca; c_wdata = v.cd;
      h_req = v.hr; h_we = v.hw; h_addr = v.ha; h_wdata = v.hd; h_lock = v.lk;
   endtask

   // called 1 time unit after a posedge; returns 1 time unit after the next one
   task automatic run_cycle();
      int          win;
      logic        ew, we;
      logic [15:0] ea, ed;
      #4;
      win = rst ? 0 : pick(c_req, h_req, h_lock);
      ea = (win == 1) ? c_addr  : (win == 2) ? h_addr  : 16'h0;
      ed = (win == 1) ? c_wdata : (win == 2) ? h_wdata : 16'h0;
      ew = (win == 1) ? c_we    : (win == 2) ? h_we    : 1'b0;
      chk("c_gnt",    c_gnt,    win == 1);
      chk("h_gnt",    h_gnt,    win == 2);
      chk("c_stall",  c_stall,  c_req && win != 1);
      chk("m_wen",    m_wen,    ew);
      chk("m_addr",   m_addr,   ea);
      chk("m_wdata",  m_wdata,  ed);
      chk("c_rvalid", c_rvalid, rst ? 1'b0 : mdl_crv);
      chk("c_rdata",  c_rdata,  rst ? 16'h0 : mdl_crd);
      chk("h_rvalid", h_rvalid, rst ? 1'b0 : mdl_hrv);
      chk("h_rdata",  h_rdata,  rst ? 16'h0 : mdl_hrd);
      if (!rst && c_req && win != 1) begin
         starve++;
         chk("starve_bound", starve > MAX, 0);
      end else begin
         starve = 0;
      end
      snap_cg = c_gnt; snap_hg = h_gnt; snap_crv = c_rvalid; snap_crd = c_rdata;
      snap_hrv = h_rvalid; snap_hrd = h_rdata;

      if (rst) begin
         mdl_last = 1; mdl_hold = 0;
         mdl_crv = 0; mdl_hrv = 0; mdl_crd = 0; mdl_hrd = 0;
      end else begin
         mdl_crv = 0; mdl_hrv = 0;
         if (win != 0) begin
            we = ew;
            mdl_last = win - 1;
            if (!we) begin
               if (win == 1) begin mdl_crv = 1; mdl_crd = ref_mem[ea[7:0]]; end
               else          begin mdl_hrv = 1; mdl_hrd = ref_mem[ea[7:0]]; end
            end else begin
               ref_mem[ea[7:0]] = ed;
            end
         end
         if (win == 2 && c_req)        mdl_hold = (mdl_hold < MAX) ? mdl_hold + 1 : MAX;
         else if (win == 1 || !c_req)  mdl_hold = 0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
         ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      end

      // core only: write then read back
      tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0));               post(0,0,0,0);
      tbl.push_back(mk(0,1,1,16'h5,16'hBEEF, 0,0,0,0,0, 1));   post(0,0,0,0);
      tbl.push_back(mk(0,1,0,16'h5,0, 0,0,0,0,0, 1));          post(0,0,0,0);
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0));              post(1,16'hBEEF,0,0);
      // contention, no lock
      tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0));              post(0,0,0,0);
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,0,16'h5,0, 1,0,16'h5,0,0, (i % 2 == 0) ? 1 : 2));
      tbl[tbl.size()-4].chk = 1;
      post(1,16'hBEEF,0,16'hBEEF);
      tbl[tbl.size()-3].chk = 1; tbl[tbl.size()-3].ecv = 1; tbl[tbl.size()-3].ecd = 16'hBEEF;
      tbl[tbl.size()-2].chk = 1; tbl[tbl.size()-2].ecd = 16'hBEEF;
      tbl[tbl.size()-2].ehv = 1; tbl[tbl.size()-2].ehd = 16'hBEEF;
      // reset drops the pending host response
      tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0));              post(0,0,0,0);
      // host lock, both requesting
      for (int i = 0; i < 10; i++) tbl.push_back(mk(0,1,0,16'h5,0, 1,0,16'h5,0,1, (i % 5 == 4) ? 1 : 2));
      tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0));
      // lock with core idle, then core joins
      for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,0,0, 1,0,16'h5,0,1, 2));
      for (int i = 0; i < 5; i++)  tbl.push_back(mk(0,1,0,16'h5,0, 1,0,16'h5,0,1, (i < 4) ? 2 : 1));
      // reset mid-read
      tbl.push_back(mk(0,1,0,16'h5,0, 0,0,0,0,0, 1));
      tbl.push_back(mk(1,1,0,16'h5,0, 0,0,0,0,0, 0));          post(0,0,0,0);
      tbl.push_back(mk(0,1,0,16'h5,0, 1,0,16'h5,0,0, 1));     post(0,0,0,0);
      tbl.push_back(mk(0,1,0,16'h5,0, 1,0,16'h5,0,0, 2));     post(1,16'hBEEF,0,0);
      // simultaneous write/read to 0x10
      tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0));
      tbl.push_back(mk(0,1,1,16'h10,16'h1234, 1,0,16'h10,0,0, 1));
      tbl.push_back(mk(0,0,0,0,0, 1,0,16'h10,0,0, 2));         post(0,0,0,0);
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0));              post(0,0,1,16'h1234);

      @(posedge clk);
      #1;
      foreach (tbl[i]) begin
         drive(tbl[i]);
         run_cycle();
         chk($sformatf("tbl%0d_gnt", i), {snap_hg, snap_cg},
             (tbl[i].eg == 1) ? 2'b01 : (tbl[i].eg == 2) ? 2'b10 : 2'b00);
         if (tbl[i].chk) begin
            chk($sformatf("tbl%0d_c_rvalid", i), snap_crv, tbl[i].ecv);
            chk($sformatf("tbl%0d_c_rdata", i),  snap_crd, tbl[i].ecd);
            chk($sformatf("tbl%0d_h_rvalid", i), snap_hrv, tbl[i].ehv);
            chk($sformatf("tbl%0d_h_rdata", i),  snap_hrd, tbl[i].ehd);
         end
      end

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst     = ($urandom_range(0, 63) == 0);
         c_req   = ($urandom_range(0, 3) != 0);
         c_we    = $urandom_range(0, 1);
         c_addr  = 16'($urandom_range(0, 31));
         c_wdata = 16'($urandom);
         h_req   = ($urandom_range(0, 3) != 0);
         h_we    = $urandom_range(0, 1);
         h_addr  = 16'($urandom_range(0, 31));
         h_wdata = 16'($urandom);
         h_lock  = $urandom_range(0, 1);
         run_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between two requesters: the RiSC-16 core's load/store path (port C) and a host/debug loader (port H).
- Muxes the address, write data and write enable onto the memory.
- Returns registered read data to the winning requester.
- Drives a stall to the core when the core loses arbitration.
- Policy: round-robin on contention, plus a bounded host lock for burst loading.

Parameters:
- p_ADDR_LEN, 16, address width on all ports.
- p_WORD_LEN, 16, data width on all ports.
- p_MAX_HOLD, 4, maximum consecutive host grants under lock while the core is requesting (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- c_req  in  1  core request; held with fields stable until granted.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  p_ADDR_LEN  core address.
- c_wdata  in  p_WORD_LEN  core write data.
- c_gnt  out  1  core granted this cycle (combinational).
- c_stall  out  1  c_req & ~c_gnt.
- c_rvalid  out  1  core read data valid (registered, 1-cycle pulse).
- c_rdata  out  p_WORD_LEN  core read data (registered).
- h_req, h_we, h_addr, h_wdata  in  1/1/p_ADDR_LEN/p_WORD_LEN  host request fields, same rules as core.
- h_lock  in  1  host requests consecutive priority.
- h_gnt, h_rvalid, h_rdata  out  1/1/p_WORD_LEN  host equivalents of c_gnt/c_rvalid/c_rdata.
- m_addr  out  p_ADDR_LEN  memory address.
- m_wdata  out  p_WORD_LEN  memory write data.
- m_wen  out  1  memory write enable.
- m_rdata  in  p_WORD_LEN  memory combinational read data.

Behaviour:
- Transfer rule: a transfer occurs on a posedge where req & gnt. At most one grant per cycle; c_gnt & h_gnt is never 1.
- State registers:
  - last_win: 0 = core, 1 = host; reset 1.
  - hold_cnt: width clog2(p_MAX_HOLD+1); reset 0.
  - c_rvalid, h_rvalid: reset 0.
  - c_rdata, h_rdata: reset 0.
- Grant decision (combinational; forced 0 while rst = 1):
  - Neither requesting: no grant. m_wen = 0, m_addr = 0, m_wdata = 0.
  - Exactly one requesting: that port wins.
  - Both requesting, h_lock = 1 and hold_cnt < p_MAX_HOLD: host wins.
  - Both requesting otherwise: the port != last_win wins (round-robin).
- Memory mux: m_addr, m_wdata and m_wen = x_we come from the granted port. m_wen is asserted only while granted.
- On each granted transfer:
  - last_win <= winner.
  - If the transfer is a read (we = 0): x_rdata <= m_rdata and x_rvalid <= 1 on that posedge. The response is visible the cycle after the grant.
  - x_rvalid is 0 in every other cycle.
  - x_rdata holds its value until the next read on that port.
  - Writes produce no rvalid.
- hold_cnt update, evaluated each posedge:
  - Host granted while c_req = 1: hold_cnt += 1, saturating at p_MAX_HOLD.
  - Core granted, or c_req = 0: hold_cnt <= 0.
  - Otherwise: unchanged.
- Starvation bound: with c_req held, the core is granted within p_MAX_HOLD+1 cycles.
- Idle cycles leave last_win unchanged.
- Address/data pass through unmodified; no range checking (the memory handles wrap/size).
- Reset mid-operation: a pending read response is dropped (rvalid 0 the next cycle) and all state returns to reset values. After reset, the first contested cycle grants the core (last_win = 1).
- Requester changing fields while stalled: permitted. Only the fields present in the grant cycle are used.

Test Plan:
- Core only: c_req = 1, c_we = 1, c_addr = 0x0005, c_wdata = 0xBEEF. Expect c_gnt = 1, m_wen = 1, m_addr = 5, c_stall = 0, no rvalid. Then a read of 5: c_rvalid = 1 next cycle with c_rdata = 0xBEEF.
- Contention, no lock, both reading continuously after reset. Expect the grant sequence C, H, C, H. Each rvalid pulses one cycle after its grant. c_stall = 1 on H cycles.
- Host lock with p_MAX_HOLD = 4, both requesting, h_lock = 1. Expect H, H, H, H, C, H, H, H, H, C. hold_cnt resets after each core grant.
- Lock with core idle: h_lock = 1, c_req = 0 for 10 cycles. Expect h_gnt every cycle and hold_cnt staying 0. When c_req rises, the host still wins 4 more cycles, then the core.
- Reset mid-read: core read granted at cycle N, rst = 1 at cycle N+1. Expect c_rvalid = 0 at N+1, all gnts 0 and rdata 0 during reset. The first contested cycle after reset grants the core.
- Simultaneous write and read to address 0x0010: both requesting, core write 0x1234 wins first. The host read in the following cycle returns h_rdata = 0x1234 with h_rvalid pulsing one cycle after its grant.
